inst_prefetch_queue: RTL and testbench

- Parametrised instruction prefetch queue between the instruction memory port and the fetch/decode stage.
- Keeps up to `MAX_OUTSTANDING` sequential (+4) fetch requests in flight and buffers returned instructions in a `DEPTH`-entry FIFO.
- On a backend redirect it flushes the FIFO in one cycle and discards stale in-flight responses using an epoch tag.
- Issue is credit-based: every issued request has a reserved FIFO slot, so memory responses are never back-pressured.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo_mem.sv | 51 +++++
 rtl/inst_prefetch_queue.sv | 211 +++++++++++++++++++++
 tb/tb_inst_prefetch_queue.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction prefetch queue.
//   XLEN          : address / instruction word width
//   INST_ID_W     : width of the running instruction id
//   fetch_entry_t : one buffered fetch result {addr, inst}
//   next_seq_pc   : sequential successor of a fetch address (wraps mod 2^32)
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN      = 32;
    localparam int INST_ID_W = 64;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo_mem.sv
// ----------------------------------------------------------------------------
// fetch_fifo_mem
// DEPTH-entry storage for returned fetch results. Synchronous write port,
// asynchronous read at the read pointer. Entry 0 is cleared on reset so the
// head entry reads as all-zero straight after reset.
// Ports:
//   clk        : clock
//   i_srst     : synchronous active-high reset (clears entry 0 only)
//   i_wr_en    : write strobe
//   i_wr_ptr   : write index
//   i_wr_data  : entry to write
//   i_rd_ptr   : read index
//   o_rd_data  : entry at i_rd_ptr (combinational)
// ----------------------------------------------------------------------------
module fetch_fifo_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_srst,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_ptr,
    input  fetch_entry_t     i_wr_data,
    input  logic [PTR_W-1:0] i_rd_ptr,
    output fetch_entry_t     o_rd_data
);

    fetch_entry_t w_entries [DEPTH];

    // Each entry is its own register so that only entry 0 carries a reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t r_entry;

            always_ff @(posedge clk) begin
                if (i_srst && (gi == 0)) begin
                    r_entry <= '0;
                end else if (i_wr_en && (i_wr_ptr == PTR_W'(gi))) begin
                    r_entry <= i_wr_data;
                end
            end

            assign w_entries[gi] = r_entry;
        end
    endgenerate

    assign o_rd_data = w_entries[i_rd_ptr];

endmodule

// File: rtl/inst_prefetch_queue.sv
// ----------------------------------------------------------------------------
// inst_prefetch_queue
// Instruction prefetch queue between the instruction memory port and the
// fetch/decode stage. Issues sequential (+4) fetches, up to MAX_OUTSTANDING in
// flight, and buffers the results in a DEPTH-entry FIFO. A request is only
// issued when a FIFO slot is reserved for it, so responses never stall.
// A redirect flushes the FIFO in one cycle and bumps the epoch; in-flight
// responses carrying an old epoch are dropped on arrival.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   redir_valid, redir_addr             : backend redirect and new fetch PC
//   out_valid, out_ready                : head handshake towards decode
//   out_addr, out_inst, out_inst_id     : head PC, instruction word, id
//   mem_req_valid, mem_req_ready        : fetch request handshake
//   mem_req_addr, mem_req_epoch         : fetch address and epoch tag
//   mem_resp_valid                      : in-order response strobe
//   mem_resp_addr, mem_resp_inst        : echoed address, instruction word
//   mem_resp_epoch                      : echoed epoch tag
// ----------------------------------------------------------------------------
module inst_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH           = 16,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          EPOCH_W         = 3,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 redir_valid,
    input  logic [31:0]          redir_addr,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_addr,
    output logic [31:0]          out_inst,
    output logic [63:0]          out_inst_id,

    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [31:0]          mem_req_addr,
    output logic [EPOCH_W-1:0]   mem_req_epoch,

    input  logic                 mem_resp_valid,
    input  logic [31:0]          mem_resp_addr,
    input  logic [31:0]          mem_resp_inst,
    input  logic [EPOCH_W-1:0]   mem_resp_epoch
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OST_W = $clog2(MAX_OUTSTANDING + 1);

    // ------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("inst_prefetch_queue: DEPTH must be a power of two >= 2");
        end
        if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > DEPTH)) begin : g_bad_ost
            $error("inst_prefetch_queue: MAX_OUTSTANDING must be in 1..DEPTH");
        end
        // With fewer epochs than in-flight requests, a stale response could
        // alias the current epoch after wrap-around.
        if ((1 << EPOCH_W) <= MAX_OUTSTANDING) begin : g_bad_epoch
            $error("inst_prefetch_queue: 2**EPOCH_W must exceed MAX_OUTSTANDING");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]          r_pc;
    logic [EPOCH_W-1:0]   r_epoch;
    logic [CNT_W-1:0]     r_count;
    logic [OST_W-1:0]     r_outstanding;
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [63:0]          r_inst_id;

    logic [31:0]          w_pc_next;
    logic [EPOCH_W-1:0]   w_epoch_next;
    logic [CNT_W-1:0]     w_count_next;
    logic [OST_W-1:0]     w_outstanding_next;
    logic [PTR_W-1:0]     w_head_next;
    logic [PTR_W-1:0]     w_tail_next;
    logic [63:0]          w_inst_id_next;

    // ------------------------------------------------------------------
    // Issue: credits cover both buffered entries and requests in flight.
    // A redirect frees every buffered entry this cycle, so those credits
    // are already available to the redirected request.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]     w_count_eff;
    logic [31:0]          w_credit_used;
    logic                 w_req_fire;
    logic [EPOCH_W-1:0]   w_epoch_inc;

    assign w_count_eff   = redir_valid ? '0 : r_count;
    assign w_credit_used = 32'(w_count_eff) + 32'(r_outstanding);
    assign w_epoch_inc   = r_epoch + EPOCH_W'(1);

    assign mem_req_valid = !reset
                           && (w_credit_used < 32'(DEPTH))
                           && (32'(r_outstanding) < 32'(MAX_OUTSTANDING));
    assign mem_req_addr  = redir_valid ? redir_addr : r_pc;
    assign mem_req_epoch = redir_valid ? w_epoch_inc : r_epoch;
    assign w_req_fire    = mem_req_valid && mem_req_ready;

    // ------------------------------------------------------------------
    // Response and output handshakes
    // ------------------------------------------------------------------
    logic                 w_resp_keep;
    logic                 w_wr_en;
    logic                 w_accept;
    fetch_entry_t         w_wr_data;
    fetch_entry_t         w_head_entry;

    assign w_resp_keep    = mem_resp_valid && (mem_resp_epoch == r_epoch) && !redir_valid;
    assign w_wr_en        = w_resp_keep && !reset;
    assign w_wr_data.addr = mem_resp_addr;
    assign w_wr_data.inst = mem_resp_inst;

    assign out_valid   = (r_count != '0) && !redir_valid;
    assign w_accept    = out_valid && out_ready;
    assign out_addr    = w_head_entry.addr;
    assign out_inst    = w_head_entry.inst;
    assign out_inst_id = r_inst_id;

    fetch_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo_mem (
        .clk       (clk),
        .i_srst    (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_ptr  (r_tail),
        .i_wr_data (w_wr_data),
        .i_rd_ptr  (r_head),
        .o_rd_data (w_head_entry)
    );

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_next          = r_pc;
        w_epoch_next       = r_epoch;
        w_count_next       = r_count;
        w_outstanding_next = r_outstanding
                             + OST_W'(w_req_fire)
                             - OST_W'(mem_resp_valid);
        w_head_next        = r_head;
        w_tail_next        = r_tail + PTR_W'(w_resp_keep);
        w_inst_id_next     = r_inst_id;

        // mem_req_addr already selects redir_addr during a redirect, so a
        // fire always continues from the address that just went out.
        if (w_req_fire) begin
            w_pc_next = next_seq_pc(mem_req_addr);
        end else if (redir_valid) begin
            w_pc_next = redir_addr;
        end

        if (redir_valid) begin
            // Everything buffered is dropped by snapping head to tail; no
            // write or accept can happen in a redirect cycle.
            w_head_next    = r_tail;
            w_count_next   = '0;
            w_epoch_next   = w_epoch_inc;
            w_inst_id_next = r_inst_id + 64'd1;
        end else begin
            w_count_next = r_count + CNT_W'(w_resp_keep) - CNT_W'(w_accept);
            w_head_next  = r_head + PTR_W'(w_accept);
            if (w_accept) begin
                w_inst_id_next = r_inst_id + 64'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_epoch       <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_inst_id     <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_epoch       <= w_epoch_next;
            r_count       <= w_count_next;
            r_outstanding <= w_outstanding_next;
            r_head        <= w_head_next;
            r_tail        <= w_tail_next;
            r_inst_id     <= w_inst_id_next;
        end
    end

    // The credit scheme must make a write into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_wr_en && (r_count == CNT_W'(DEPTH))))
                else $error("inst_prefetch_queue: write with FIFO full");
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_inst_prefetch_queue
// Randomised bench for inst_prefetch_queue. A memory model answers requests in
// order after a programmable latency; a behavioural reference model (queues of
// buffered addresses and in-flight requests) predicts every output.
// ----------------------------------------------------------------------------
module tb_inst_prefetch_queue;

    localparam int          DEPTH   = 16;
    localparam int          MAX_OST = 4;
    localparam int          EPOCH_W = 3;
    localparam logic [31:0] RST_PC  = 32'h0;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 redir_valid;
    logic [31:0]          redir_addr;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_addr;
    logic [31:0]          out_inst;
    logic [63:0]          out_inst_id;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [31:0]          mem_req_addr;
    logic [EPOCH_W-1:0]   mem_req_epoch;
    logic                 mem_resp_valid;
    logic [31:0]          mem_resp_addr;
    logic [31:0]          mem_resp_inst;
    logic [EPOCH_W-1:0]   mem_resp_epoch;

    always #5 clk = ~clk;

    inst_prefetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OST),
        .EPOCH_W         (EPOCH_W),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redir_valid    (redir_valid),
        .redir_addr     (redir_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_inst       (out_inst),
        .out_inst_id    (out_inst_id),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_epoch  (mem_req_epoch),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_addr  (mem_resp_addr),
        .mem_resp_inst  (mem_resp_inst),
        .mem_resp_epoch (mem_resp_epoch)
    );

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0]        addr;
        logic [EPOCH_W-1:0] epoch;
        int                 due;
    } mreq_t;

    mreq_t mem_q[$];
    int    mem_lat;
    int    cyc;
    int    fires_seen;

    // ---------------- reference model ----------------
    logic [31:0]        m_fifo[$];   // addresses buffered, head first
    int                 m_ost;       // requests in flight (incl. stale)
    logic [31:0]        m_pc;
    logic [EPOCH_W-1:0] m_epoch;
    logic [63:0]        m_id;
    logic [31:0]        m_stream;    // next address decode must see

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom();
        if (r[3:0] == 4'd0) return 32'hFFFF_FFF0 + {28'd0, r[5:4], 2'b00};
        return {r[31:2], 2'b00};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        m_fifo.delete();
        m_ost    = 0;
        m_pc     = RST_PC;
        m_epoch  = '0;
        m_id     = 64'd0;
        m_stream = RST_PC;
        cyc      = 0;
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        redir_valid    = 1'b0;
        redir_addr     = 32'h0;
        out_ready      = 1'b1;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_addr  = 32'h0;
        mem_resp_inst  = 32'h0;
        mem_resp_epoch = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req_valid", mem_req_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_id", out_inst_id, 64'd0);
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update at posedge.
    task automatic step(input logic redir, input logic [31:0] raddr,
                        input logic oready, input logic mready);
        logic               rvalid, exp_rv, exp_ov, fire_m, acc_m, wr_m;
        logic [31:0]        r_a;
        logic [EPOCH_W-1:0] r_e, exp_ep;
        int                 ceff;

        redir_valid   = redir;
        redir_addr    = raddr;
        out_ready     = oready;
        mem_req_ready = mready;
        rvalid = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        r_a = 32'h0;
        r_e = '0;
        if (rvalid) begin
            r_a = mem_q[0].addr;
            r_e = mem_q[0].epoch;
            mem_resp_addr  = r_a;
            mem_resp_inst  = inst_of(r_a);
            mem_resp_epoch = r_e;
        end else begin
            mem_resp_addr  = $urandom();
            mem_resp_inst  = $urandom();
            mem_resp_epoch = EPOCH_W'($urandom());
        end
        mem_resp_valid = rvalid;

        @(negedge clk);
        ceff   = redir ? 0 : m_fifo.size();
        exp_rv = ((ceff + m_ost) < DEPTH) && (m_ost < MAX_OST);
        check("req_valid", mem_req_valid, exp_rv);
        if (exp_rv) begin
            exp_ep = redir ? EPOCH_W'(m_epoch + 1) : m_epoch;
            check("req_addr", mem_req_addr, redir ? raddr : m_pc);
            check("req_epoch", mem_req_epoch, exp_ep);
        end
        exp_ov = (m_fifo.size() != 0) && !redir;
        check("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            check("out_addr", out_addr, m_fifo[0]);
            check("out_inst", out_inst, inst_of(m_fifo[0]));
        end
        check("out_inst_id", out_inst_id, m_id);

        fire_m = exp_rv && mready;
        acc_m  = exp_ov && oready;
        wr_m   = rvalid && (r_e == m_epoch) && !redir;
        if (acc_m) begin
            check("addr_seq", out_addr, m_stream);
            $display("[TB] out addr=%08h inst=%08h id=%0d", out_addr, out_inst, out_inst_id);
        end
        if (mem_req_valid && mready) begin
            mem_q.push_back('{mem_req_addr, mem_req_epoch, cyc + mem_lat});
            fires_seen++;
        end

        @(posedge clk);
        #1;
        if (rvalid) begin
            mem_q.delete(0);
            m_ost--;
        end
        if (wr_m) m_fifo.push_back(r_a);
        if (fire_m) begin
            m_ost++;
            m_pc = (redir ? raddr : m_pc) + 32'd4;
        end
        if (redir) begin
            m_fifo.delete();
            m_epoch  = EPOCH_W'(m_epoch + 1);
            m_id     = m_id + 64'd1;
            m_stream = raddr;
            if (!fire_m) m_pc = raddr;
        end
        if (acc_m) begin
            m_fifo.delete(0);
            m_id     = m_id + 64'd1;
            m_stream = m_stream + 32'd4;
        end
        cyc++;
    endtask

    // Stop issuing and let the memory return everything in flight.
    task automatic drain();
        int n;
        n = 0;
        while ((mem_q.size() > 0) && (n < 64)) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            n++;
        end
        check("drain_idle", mem_q.size(), 0);
        check("drain_ost", m_ost, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        fires_seen = 0;
        mem_lat    = 1;
        model_reset();

        // Streaming with L=1: one instruction per cycle from RESET_PC.
        apply_reset();
        for (int i = 0; i < 24; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        check("stream_ids", m_id >= 64'd20, 1'b1);
        drain();

        // Consumer stalled: exactly DEPTH requests, then credit stops issue.
        apply_reset();
        fires_seen = 0;
        for (int i = 0; i < 40; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        check("fill_reqs", fires_seen, DEPTH);
        check("full_valid", out_valid, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        drain();

        // L=3: three in flight, redirect to 0x100 drops the stale ones.
        apply_reset();
        mem_lat = 3;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        drain();

        // Redirects landing on response cycles with the consumer ready.
        mem_lat = 2;
        for (int i = 0; i < 300; i++) begin
            logic rd;
            rd = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(0, 1) == 1);
            step(rd, rand_addr(), 1'b1, 1'($urandom_range(0, 3) != 0));
        end
        drain();

        // Memory ready toggling every cycle, random consumer.
        for (int p = 1; p <= 2; p++) begin
            mem_lat = p;
            for (int i = 0; i < 600; i++)
                step(($urandom_range(0, 19) == 0), rand_addr(),
                     1'($urandom_range(0, 1)), 1'(i % 2));
        end
        drain();

        // Back-to-back redirects wrap the epoch.
        apply_reset();
        mem_lat = 2;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 32'h2000 + 32'(k) * 32'h40, 1'b1, 1'b1);
            step(1'b0, 32'h0, 1'b1, 1'b1);
        end
        check("epoch_wrap", m_epoch, EPOCH_W'(10));
        for (int i = 0; i < 30; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        drain();

        // Long fully random run.
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) mem_lat = $urandom_range(1, 4);
            step(($urandom_range(0, 15) == 0), rand_addr(),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end
        drain();

        // Reset mid-operation with data buffered: entry 0 reads back as zero.
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        drain();
        apply_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
